// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one frame-buffer RAM port between display reads (priority) and a 4-deep write FIFO.
// Define FB_CLEAR_EN to add the full-buffer clear engine (clr_start/clr_busy, CLEAR_COLOR).
module fb_port_arbiter #(
   parameter int          FB_W         = 320,
   parameter int          FB_H         = 200,
`ifdef FB_CLEAR_EN
   parameter logic [15:0] CLEAR_COLOR  = 16'h0000,
`endif
   parameter logic [15:0] BORDER_COLOR = 16'h0000
) (
   input  logic        PixelClk,
   input  logic        nRST,
   input  logic        disp_req,
   input  logic [8:0]  disp_x,
   input  logic [7:0]  disp_y,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   input  logic        wr_valid,
   input  logic [15:0] wr_addr,
   input  logic [15:0] wr_data,
   output logic        wr_ready,
   output logic [2:0]  fifo_level,
   output logic        ram_ce,
   output logic        ram_we,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_wdata,
`ifdef FB_CLEAR_EN
   input  logic        clr_start,
   output logic        clr_busy,
`endif
   input  logic [15:0] ram_rdata
);
   localparam logic [15:0] FB_SIZE = 16'(FB_W * FB_H);
   typedef enum logic [1:0] {IDLE, DRD, WR} slot_t;
   slot_t       slot;
   logic        in_range, push, pop, clr_wr, wr_ok;
   logic [15:0] rd_addr, wa, wd;
   logic [15:0] f_addr [4];
   logic [15:0] f_data [4];
   logic [1:0]  rd_ptr, wr_ptr;
   logic        s1_valid, s1_border, s2_valid, s2_border;

   assign in_range = disp_req && int'(disp_x) < FB_W && int'(disp_y) < FB_H;
   assign rd_addr  = 16'(int'(disp_y) * FB_W + int'(disp_x));
   assign pop      = !in_range && fifo_level != 3'd0;
   assign push     = wr_valid && wr_ready;
   // out-of-range FIFO entries still pop but leave their slot idle
   assign wr_ok    = clr_wr || (pop && f_addr[rd_ptr] < FB_SIZE);
   assign slot     = in_range ? DRD : wr_ok ? WR : IDLE;

`ifdef FB_CLEAR_EN
   logic [15:0] clr_addr;
   assign clr_wr   = clr_busy && !in_range && fifo_level == 3'd0;
   assign wr_ready = fifo_level < 3'd4 && !clr_busy;
   assign wa       = clr_wr ? clr_addr : f_addr[rd_ptr];
   assign wd       = clr_wr ? CLEAR_COLOR : f_data[rd_ptr];
   always_ff @(posedge PixelClk or negedge nRST)
      if (!nRST) begin
         clr_busy <= 1'b0;
         clr_addr <= 16'd0;
      end else if (!clr_busy) begin
         clr_busy <= clr_start;
         clr_addr <= 16'd0;
      end else if (clr_wr) begin
         clr_busy <= clr_addr != FB_SIZE - 16'd1;
         clr_addr <= clr_addr + 16'd1;
      end
`else
   assign clr_wr   = 1'b0;
   assign wr_ready = fifo_level < 3'd4;
   assign wa       = f_addr[rd_ptr];
   assign wd       = f_data[rd_ptr];
`endif

   always_ff @(posedge PixelClk or negedge nRST)
      if (!nRST) begin
         ram_ce     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= 16'd0;
         ram_wdata  <= 16'd0;
         pix_data   <= 16'd0;
         pix_valid  <= 1'b0;
         s1_valid   <= 1'b0;
         s1_border  <= 1'b0;
         s2_valid   <= 1'b0;
         s2_border  <= 1'b0;
         rd_ptr     <= 2'd0;
         wr_ptr     <= 2'd0;
         fifo_level <= 3'd0;
      end else begin
         ram_ce     <= slot != IDLE;
         ram_we     <= slot == WR;
         if (slot != IDLE) ram_addr <= slot == DRD ? rd_addr : wa;
         if (slot == WR) ram_wdata <= wd;
         s1_valid   <= disp_req;
         s1_border  <= !in_range;
         s2_valid   <= s1_valid;
         s2_border  <= s1_border;
         pix_valid  <= s2_valid;
         if (s2_valid) pix_data <= s2_border ? BORDER_COLOR : ram_rdata;
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop) rd_ptr <= rd_ptr + 2'd1;
         fifo_level <= fifo_level + {2'b0, push} - {2'b0, pop};
      end

   always_ff @(posedge PixelClk)
      if (push) begin
         f_addr[wr_ptr] <= wr_addr;
         f_data[wr_ptr] <= wr_data;
      end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fb_port_arbiter;
   logic        PixelClk = 1'b0;
   logic        nRST = 1'b0;
   logic        disp_req = 1'b0;
   logic [8:0]  disp_x = 9'd0;
   logic [7:0]  disp_y = 8'd0;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_addr = 16'd0;
   logic [15:0] wr_data = 16'd0;
   logic        wr_ready;
   logic [2:0]  fifo_level;
   logic        ram_ce, ram_we;
   logic [15:0] ram_addr, ram_wdata;
   logic [15:0] ram_rdata = 16'd0;
`ifdef FB_CLEAR_EN
   logic        clr_start = 1'b0;
   logic        clr_busy;
`endif
   logic [15:0] wmem [65536];
   bit          wrt [65536];
   int          n_pass = 0;
   int          n_chk = 0;

   fb_port_arbiter dut (
      .PixelClk(PixelClk), .nRST(nRST),
      .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
      .pix_data(pix_data), .pix_valid(pix_valid),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ready(wr_ready), .fifo_level(fifo_level),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef FB_CLEAR_EN
      .clr_start(clr_start), .clr_busy(clr_busy),
`endif
      .ram_rdata(ram_rdata)
   );

   always #5 PixelClk = ~PixelClk;

   // RAM model: unwritten words read back as addr ^ 16'h5A5A, one cycle read latency
   always @(posedge PixelClk)
      if (ram_ce) begin
         if (ram_we) begin
            wmem[ram_addr] <= ram_wdata;
            wrt[ram_addr]  <= 1'b1;
         end else ram_rdata <= wrt[ram_addr] ? wmem[ram_addr] : ram_addr ^ 16'h5A5A;
      end

   function automatic logic [15:0] pix_ref(int x, int y);
      return (x < 320 && y < 200) ? 16'(y * 320 + x) ^ 16'h5A5A : 16'h0000;
   endfunction

   task automatic tick();
      @(posedge PixelClk);
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      repeat (2) tick();
      n_chk++;
      if ({ram_ce, ram_we, pix_valid, fifo_level, ram_addr, ram_wdata, pix_data} !== '0 || wr_ready !== 1'b1)
         $display("FAIL reset_init: ce=%b we=%b addr=%h wdata=%h pix=%h pv=%b lvl=%0d rdy=%b, want zeros and rdy=1",
                  ram_ce, ram_we, ram_addr, ram_wdata, pix_data, pix_valid, fifo_level, wr_ready);
      else n_pass++;
      nRST = 1'b1;
      tick();
      disp_req = 1'b1; disp_x = 9'd5; disp_y = 8'd2;
      wr_valid = 1'b1; wr_addr = 16'd40000; wr_data = 16'h1234;
      repeat (3) tick();
`ifdef FB_CLEAR_EN
      clr_start = 1'b1;
`endif
      tick();
`ifdef FB_CLEAR_EN
      clr_start = 1'b0;
`endif
      #2 nRST = 1'b0;
      #1;
      n_chk++;
      if ({ram_ce, ram_we, pix_valid, fifo_level, ram_addr, ram_wdata, pix_data} !== '0 || wr_ready !== 1'b1)
         $display("FAIL reset_mid: ce=%b we=%b addr=%h wdata=%h pix=%h pv=%b lvl=%0d rdy=%b, want zeros and rdy=1",
                  ram_ce, ram_we, ram_addr, ram_wdata, pix_data, pix_valid, fifo_level, wr_ready);
      else n_pass++;
`ifdef FB_CLEAR_EN
      n_chk++;
      if (clr_busy !== 1'b0) $display("FAIL reset_clr_busy: got %b want 0", clr_busy);
      else n_pass++;
`endif
      disp_req = 1'b0; wr_valid = 1'b0;
      repeat (2) tick();
      nRST = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_chk++;
         if (pix_valid !== 1'b0 || ram_ce !== 1'b0 || fifo_level !== 3'd0)
            $display("FAIL reset_quiet: cyc %0d pv=%b ce=%b lvl=%0d, want 0 0 0", i, pix_valid, ram_ce, fifo_level);
         else n_pass++;
      end
   endtask

   task automatic test_read_basic();
      logic [15:0] exp = pix_ref(5, 2);
      disp_req = 1'b1; disp_x = 9'd5; disp_y = 8'd2;
      tick();
      disp_req = 1'b0;
      n_chk++;
      if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'd645)
         $display("FAIL rd_addr: ce=%b we=%b addr=%0d want 1 0 645", ram_ce, ram_we, ram_addr);
      else n_pass++;
      tick();
      n_chk++;
      if (pix_valid !== 1'b0) $display("FAIL rd_early: pix_valid=%b at N+2 want 0", pix_valid);
      else n_pass++;
      tick();
      n_chk++;
      if (pix_valid !== 1'b1 || pix_data !== exp)
         $display("FAIL rd_data: pv=%b pix=%h want 1 %h", pix_valid, pix_data, exp);
      else n_pass++;
      tick();
      n_chk++;
      if (pix_valid !== 1'b0 || pix_data !== exp)
         $display("FAIL rd_hold: pv=%b pix=%h want 0 %h", pix_valid, pix_data, exp);
      else n_pass++;
      repeat (3) tick();
   endtask

   task automatic test_border();
      logic [15:0] exp = pix_ref(319, 199);
      disp_req = 1'b1; disp_x = 9'd330; disp_y = 8'd10;
      tick();
      disp_req = 1'b0;
      n_chk++;
      if (ram_ce !== 1'b0) $display("FAIL border_ce: ce=%b want 0", ram_ce);
      else n_pass++;
      repeat (2) tick();
      n_chk++;
      if (pix_valid !== 1'b1 || pix_data !== 16'h0000)
         $display("FAIL border_pix: pv=%b pix=%h want 1 0000", pix_valid, pix_data);
      else n_pass++;
      disp_req = 1'b1; disp_x = 9'd319; disp_y = 8'd199;
      tick();
      disp_req = 1'b0;
      n_chk++;
      if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'd63999)
         $display("FAIL corner_addr: ce=%b we=%b addr=%0d want 1 0 63999", ram_ce, ram_we, ram_addr);
      else n_pass++;
      repeat (2) tick();
      n_chk++;
      if (pix_valid !== 1'b1 || pix_data !== exp)
         $display("FAIL corner_pix: pv=%b pix=%h want 1 %h", pix_valid, pix_data, exp);
      else n_pass++;
      repeat (3) tick();
   endtask

   task automatic test_fifo_full();
      logic [15:0] a [5];
      logic [15:0] d [5];
      disp_req = 1'b1; disp_x = 9'd3; disp_y = 8'd1;
      for (int i = 0; i < 5; i++) begin
         a[i] = 16'(32000 + i * 7);
         d[i] = 16'($urandom);
         wr_valid = 1'b1; wr_addr = a[i]; wr_data = d[i];
         n_chk++;
         if (wr_ready !== (i < 4)) $display("FAIL full_ready: push %0d rdy=%b want %b", i, wr_ready, i < 4);
         else n_pass++;
         tick();
         n_chk++;
         if (ram_ce === 1'b1 && ram_we === 1'b1) $display("FAIL full_starve: write issued at addr %0d, want none", ram_addr);
         else n_pass++;
      end
      wr_valid = 1'b0;
      n_chk++;
      if (fifo_level !== 3'd4 || wr_ready !== 1'b0)
         $display("FAIL full_level: lvl=%0d rdy=%b want 4 0", fifo_level, wr_ready);
      else n_pass++;
      disp_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_chk++;
         if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== a[i] || ram_wdata !== d[i])
            $display("FAIL drain_wr: %0d ce=%b we=%b addr=%0d data=%h want 1 1 %0d %h",
                     i, ram_ce, ram_we, ram_addr, ram_wdata, a[i], d[i]);
         else n_pass++;
      end
      n_chk++;
      if (fifo_level !== 3'd0) $display("FAIL drain_level: lvl=%0d want 0", fifo_level);
      else n_pass++;
      repeat (4) tick();
   endtask

   task automatic test_priority();
      disp_req = 1'b1; disp_x = 9'd7; disp_y = 8'd3;
      wr_valid = 1'b1; wr_addr = 16'd33333; wr_data = 16'hBEEF;
      tick();
      wr_valid = 1'b0; disp_x = 9'd8;
      n_chk++;
      if (fifo_level !== 3'd1) $display("FAIL prio_level1: lvl=%0d want 1", fifo_level);
      else n_pass++;
      tick();
      disp_req = 1'b0;
      wr_valid = 1'b1; wr_addr = 16'd44444; wr_data = 16'hCAFE;
      n_chk++;
      if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 16'd968)
         $display("FAIL prio_read: ce=%b we=%b addr=%0d want 1 0 968", ram_ce, ram_we, ram_addr);
      else n_pass++;
      tick();
      wr_valid = 1'b0;
      n_chk++;
      if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'd33333 || ram_wdata !== 16'hBEEF)
         $display("FAIL prio_write: ce=%b we=%b addr=%0d data=%h want 1 1 33333 beef", ram_ce, ram_we, ram_addr, ram_wdata);
      else n_pass++;
      n_chk++;
      if (fifo_level !== 3'd1) $display("FAIL prio_pushpop: lvl=%0d want 1", fifo_level);
      else n_pass++;
      tick();
      n_chk++;
      if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'd44444 || ram_wdata !== 16'hCAFE)
         $display("FAIL prio_write2: ce=%b we=%b addr=%0d data=%h want 1 1 44444 cafe", ram_ce, ram_we, ram_addr, ram_wdata);
      else n_pass++;
      repeat (4) tick();
   endtask

   task automatic test_random();
      logic [31:0] q [$];
      logic [31:0] e;
      logic [15:0] ea, ed;
      logic        pv [3];
      logic [15:0] pd [3];
      int          kind, thr;
      bit          inr, acc, ok;
      kind = 0; ea = 16'd0; ed = 16'd0;
      pv = '{1'b0, 1'b0, 1'b0};
      pd = '{16'd0, 16'd0, 16'd0};
      for (int k = 0; k < 3000; k++) begin
         n_chk++;
         if (fifo_level !== 3'(q.size()) || wr_ready !== (q.size() < 4))
            $display("FAIL rnd_level: cyc %0d lvl=%0d rdy=%b want %0d %b", k, fifo_level, wr_ready, q.size(), q.size() < 4);
         else n_pass++;
         ok = kind == 0 ? ram_ce === 1'b0 :
              kind == 1 ? (ram_ce === 1'b1 && ram_we === 1'b0 && ram_addr === ea) :
                          (ram_ce === 1'b1 && ram_we === 1'b1 && ram_addr === ea && ram_wdata === ed);
         n_chk++;
         if (!ok)
            $display("FAIL rnd_ram: cyc %0d ce=%b we=%b addr=%0d data=%h want kind %0d addr=%0d data=%h",
                     k, ram_ce, ram_we, ram_addr, ram_wdata, kind, ea, ed);
         else n_pass++;
         n_chk++;
         if (pix_valid !== pv[2] || (pv[2] && pix_data !== pd[2]))
            $display("FAIL rnd_pix: cyc %0d pv=%b pix=%h want %b %h", k, pix_valid, pix_data, pv[2], pd[2]);
         else n_pass++;
         thr = k < 1000 ? 33 : k < 2000 ? 60 : 90;
         disp_req = $urandom_range(0, 99) < thr;
         disp_x   = 9'($urandom_range(0, 340));
         disp_y   = $urandom_range(0, 15) == 0 ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 99));
         wr_valid = $urandom_range(0, 1) == 1;
         wr_addr  = 16'($urandom_range(32000, 65535));
         wr_data  = 16'($urandom);
         inr = disp_req && disp_x < 320 && disp_y < 200;
         acc = wr_valid && q.size() < 4;
         pv[2] = pv[1]; pd[2] = pd[1];
         pv[1] = pv[0]; pd[1] = pd[0];
         pv[0] = disp_req; pd[0] = pix_ref(disp_x, disp_y);
         kind = 0;
         if (inr) begin
            kind = 1;
            ea = 16'(disp_y * 320 + disp_x);
         end else if (q.size() > 0) begin
            e = q.pop_front();
            if (e[31:16] < 16'd64000) begin
               kind = 2; ea = e[31:16]; ed = e[15:0];
            end
         end
         if (acc) q.push_back({wr_addr, wr_data});
         tick();
      end
      disp_req = 1'b0; wr_valid = 1'b0;
      repeat (8) tick();
   endtask

`ifdef FB_CLEAR_EN
   task automatic test_clear();
      logic [15:0] fa [2];
      logic [15:0] fd [2];
      logic [15:0] exp_a, bad_a, bad_d, bad_e, prev_a;
      int          k, nfw, nclr, bad;
      bit          prev_rd;
      fa = '{16'd50000, 16'd50001};
      fd = '{16'h1111, 16'h2222};
      exp_a = 16'd0; bad_a = 16'd0; bad_d = 16'd0; bad_e = 16'd0; prev_a = 16'd0;
      k = 0; nfw = 0; nclr = 0; bad = 0; prev_rd = 1'b0;
      disp_req = 1'b1; disp_x = 9'd0; disp_y = 8'd0;
      wr_valid = 1'b1; wr_addr = fa[0]; wr_data = fd[0];
      tick();
      wr_addr = fa[1]; wr_data = fd[1];
      tick();
      wr_valid = 1'b0; disp_req = 1'b0; clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      n_chk++;
      if (clr_busy !== 1'b1 || wr_ready !== 1'b0) $display("FAIL clr_start: busy=%b rdy=%b want 1 0", clr_busy, wr_ready);
      else n_pass++;
      while (k < 70000) begin
         if (prev_rd) begin
            n_chk++;
            if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== prev_a)
               $display("FAIL clr_rd: cyc %0d ce=%b we=%b addr=%0d want 1 0 %0d", k, ram_ce, ram_we, ram_addr, prev_a);
            else n_pass++;
         end
         if (ram_ce === 1'b1 && ram_we === 1'b1) begin
            if (nfw < 2) begin
               n_chk++;
               if (ram_addr !== fa[nfw] || ram_wdata !== fd[nfw])
                  $display("FAIL clr_fifo: %0d addr=%0d data=%h want %0d %h", nfw, ram_addr, ram_wdata, fa[nfw], fd[nfw]);
               else n_pass++;
               nfw++;
            end else begin
               if (ram_addr !== exp_a || ram_wdata !== 16'h0000) begin
                  if (bad == 0) begin bad_a = ram_addr; bad_d = ram_wdata; bad_e = exp_a; end
                  bad++;
               end
               nclr++;
               exp_a++;
            end
         end
         if (clr_busy !== 1'b1) break;
         disp_req  = k < 3000 && k % 3 == 0;
         disp_x    = 9'($urandom_range(0, 319));
         disp_y    = 8'($urandom_range(0, 99));
         clr_start = k == 600;
         prev_rd   = disp_req;
         prev_a    = 16'(disp_y * 320 + disp_x);
         tick();
         k++;
      end
      disp_req = 1'b0; clr_start = 1'b0;
      n_chk++;
      if (clr_busy !== 1'b0) $display("FAIL clr_timeout: busy=%b after %0d cycles want 0", clr_busy, k);
      else n_pass++;
      n_chk++;
      if (nclr !== 64000 || bad !== 0 || nfw !== 2)
         $display("FAIL clr_seq: writes=%0d bad=%0d fifo=%0d first bad addr=%0d data=%h want addr=%0d; want 64000 0 2",
                  nclr, bad, nfw, bad_a, bad_d, bad_e);
      else n_pass++;
      tick();
      n_chk++;
      if ((ram_ce === 1'b1 && ram_we === 1'b1) || wr_ready !== 1'b1)
         $display("FAIL clr_done: ce=%b we=%b rdy=%b want no write and rdy=1", ram_ce, ram_we, wr_ready);
      else n_pass++;
      disp_req = 1'b1; disp_x = 9'd5; disp_y = 8'd2;
      tick();
      disp_req = 1'b0;
      repeat (2) tick();
      n_chk++;
      if (pix_valid !== 1'b1 || pix_data !== 16'h0000)
         $display("FAIL clr_readback: pv=%b pix=%h want 1 0000", pix_valid, pix_data);
      else n_pass++;
      repeat (3) tick();
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read_basic();
      test_border();
      test_fifo_full();
      test_priority();
      test_random();
`ifdef FB_CLEAR_EN
      test_clear();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
